// File: rtl/elementwise_sum_reduce.sv
// Sequential 4-term reduction of elementwise products into one scalar sum, valid/ready on both sides.
// Optional build macro SUM_REDUCE_SAT_EN: clamp the sum to OUT_W bits and raise sat instead of truncating.
module elementwise_sum_reduce #(
    parameter int N     = 8,
    parameter int OUT_W = 2*N+2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*N-1:0]     products [0:3],
    input  logic               in_valid,
    output logic               in_ready,
    output logic [OUT_W-1:0]   sum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               pulse_sum,
    output logic [3:0]         cycle_count,
    output logic               sat
);

    localparam int ACC_W  = 2*N+2;
    localparam int WIDE_W = (OUT_W > ACC_W) ? OUT_W : ACC_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUM,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_last;
    logic [2*N-1:0]     r_prod [0:3];
    logic [ACC_W-1:0]   r_acc;
    logic [1:0]         r_idx;
    logic [3:0]         r_cnt;
    logic [OUT_W-1:0]   r_sum;
    logic               r_out_valid;
    logic               r_pulse;
    logic [ACC_W-1:0]   w_addend;
    logic [ACC_W-1:0]   w_acc_next;

    // Maps the full-precision accumulator onto the output width (clamp or truncate).
    function automatic logic [OUT_W-1:0] fit_sum(input logic [ACC_W-1:0] acc);
        logic [WIDE_W-1:0] wide;
`ifdef SUM_REDUCE_SAT_EN
        logic [WIDE_W-1:0] lim;
`endif
        wide            = '0;
        wide[ACC_W-1:0] = acc;
`ifdef SUM_REDUCE_SAT_EN
        lim             = '0;
        lim[OUT_W-1:0]  = '1;
        if (wide > lim)
            wide = lim;
`endif
        return wide[OUT_W-1:0];
    endfunction

`ifdef SUM_REDUCE_SAT_EN
    function automatic logic sat_hit(input logic [ACC_W-1:0] acc);
        logic [WIDE_W-1:0] wide;
        logic [WIDE_W-1:0] lim;
        wide            = '0;
        wide[ACC_W-1:0] = acc;
        lim             = '0;
        lim[OUT_W-1:0]  = '1;
        return (wide > lim);
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SUM;
                end
            end
            S_SUM: begin
                if (r_idx == 2'd3) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_addend   = {2'b00, r_prod[r_idx]};
    assign w_acc_next = r_acc + w_addend;

    // Operands are captured only at the accept edge; upstream may change them afterwards.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < 4; i++)
                r_prod[i] <= products[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_out_valid <= 1'b0;
            r_pulse     <= 1'b0;
        end else begin
            r_pulse <= w_last;
            if (w_accept) begin
                r_acc <= '0;
                r_idx <= '0;
                r_cnt <= '0;
            end
            if (r_state == S_SUM) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 4'd1;
                if (w_last) begin
                    r_sum       <= fit_sum(w_acc_next);
                    r_out_valid <= 1'b1;
                end else begin
                    r_idx <= r_idx + 2'd1;
                end
            end
            if (r_state == S_DONE && out_ready)
                r_out_valid <= 1'b0;
        end
    end

`ifdef SUM_REDUCE_SAT_EN
    logic r_sat;

    always_ff @(posedge clk) begin
        if (rst)
            r_sat <= 1'b0;
        else if (w_last)
            r_sat <= sat_hit(w_acc_next);
    end

    assign sat = r_sat;
`else
    assign sat = 1'b0;
`endif

    assign in_ready    = (r_state == S_IDLE);
    assign sum         = r_sum;
    assign out_valid   = r_out_valid;
    assign pulse_sum   = r_pulse;
    assign cycle_count = r_cnt;

endmodule

// File: tb/tb_elementwise_sum_reduce.sv
// Directed bench for elementwise_sum_reduce: full-width (OUT_W=18) and narrow (OUT_W=16) instances
// share one stimulus stream and are compared every cycle against a transaction-level model.
module tb_elementwise_sum_reduce;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] prod [0:3];
    logic        in_valid;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_pulse, a_sat;
    logic [17:0] a_sum;
    logic [3:0]  a_cnt;
    logic        b_in_ready, b_out_valid, b_pulse, b_sat;
    logic [15:0] b_sum;
    logic [3:0]  b_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    elementwise_sum_reduce #(.N(8)) dut_a (
        .clk(clk), .rst(rst), .products(prod), .in_valid(in_valid), .in_ready(a_in_ready),
        .sum(a_sum), .out_valid(a_out_valid), .out_ready(out_ready), .pulse_sum(a_pulse),
        .cycle_count(a_cnt), .sat(a_sat)
    );

    elementwise_sum_reduce #(.N(8), .OUT_W(16)) dut_b (
        .clk(clk), .rst(rst), .products(prod), .in_valid(in_valid), .in_ready(b_in_ready),
        .sum(b_sum), .out_valid(b_out_valid), .out_ready(out_ready), .pulse_sum(b_pulse),
        .cycle_count(b_cnt), .sat(b_sat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int narrow_sum(input int t);
`ifdef SUM_REDUCE_SAT_EN
        return (t > 65535) ? 65535 : t;
`else
        return t & 32'hFFFF;
`endif
    endfunction

    function automatic int narrow_sat(input int t);
`ifdef SUM_REDUCE_SAT_EN
        return (t > 65535) ? 1 : 0;
`else
        return (t < 0) ? 1 : 0;
`endif
    endfunction

    // Transaction model: a captured vector produces its total four edges after acceptance.
    int m_ops [4];
    int m_left  = 0;
    int m_cnt   = 0;
    int m_total = 0;
    bit m_valid = 0;
    bit m_pulse = 0;
    bit m_init  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1; m_left = 0; m_cnt = 0; m_total = 0; m_valid = 0; m_pulse = 0;
        end else if (m_init) begin
            if (m_valid) begin
                m_pulse = 0;
                if (out_ready) m_valid = 0;
            end else if (m_left > 0) begin
                m_left--;
                m_cnt++;
                if (m_left == 0) begin
                    m_total = m_ops[0] + m_ops[1] + m_ops[2] + m_ops[3];
                    m_valid = 1;
                    m_pulse = 1;
                end
            end else if (in_valid) begin
                for (int i = 0; i < 4; i++) m_ops[i] = int'(prod[i]);
                m_left = 4;
                m_cnt  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("a_in_ready",  a_in_ready,  (!m_valid && m_left == 0));
            check("a_out_valid", a_out_valid, m_valid);
            check("a_pulse",     a_pulse,     m_pulse);
            check("a_sum",       a_sum,       m_total);
            check("a_cnt",       a_cnt,       m_cnt);
            check("a_sat",       a_sat,       0);
            check("b_in_ready",  b_in_ready,  (!m_valid && m_left == 0));
            check("b_out_valid", b_out_valid, m_valid);
            check("b_pulse",     b_pulse,     m_pulse);
            check("b_sum",       b_sum,       narrow_sum(m_total));
            check("b_cnt",       b_cnt,       m_cnt);
            check("b_sat",       b_sat,       narrow_sat(m_total));
        end
    end

    task automatic send(input int p0, input int p1, input int p2, input int p3,
                        input bit hold, output int acc_cyc);
        int g = 0;
        prod[0] = 16'(p0); prod[1] = 16'(p1); prod[2] = 16'(p2); prod[3] = 16'(p3);
        in_valid = 1'b1;
        while (a_in_ready !== 1'b1 && g < 20) begin
            @(posedge clk); #1; g++;
        end
        check("accept_ready", a_in_ready, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = 0;
        while (a_out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check(name, a_out_valid, 1);
    endtask

    task automatic drain;
        @(posedge clk); #1;
        check("drain_valid", a_out_valid, 0);
        check("drain_ready", a_in_ready, 1);
    endtask

    int c1, c2, lat;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) prod[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_sum", a_sum, 0);
        check("rst_cnt", a_cnt, 0);
        rst = 1'b0;

        // Basic reduction
        send(2, 8, 18, 32, 0, c1);
        wait_valid("t1_valid", lat);
        check("t1_latency", lat, 4);
        check("t1_sum", a_sum, 60);
        check("t1_cnt", a_cnt, 4);
        check("t1_pulse", a_pulse, 1);
        check("t1_model", m_total, 60);
        @(posedge clk); #1;
        check("t1_valid_drop", a_out_valid, 0);
        check("t1_pulse_drop", a_pulse, 0);
        check("t1_idle", a_in_ready, 1);

        // Backpressure
        out_ready = 1'b0;
        send(2, 8, 18, 32, 0, c1);
        wait_valid("t2_valid", lat);
        repeat (6) begin @(posedge clk); #1; end
        check("t2_hold_valid", a_out_valid, 1);
        check("t2_hold_sum", a_sum, 60);
        check("t2_hold_ready", a_in_ready, 0);
        check("t2_hold_pulse", a_pulse, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t2_release", a_out_valid, 0);

        // Full-scale products: lossless on 18 bits, saturate or wrap on 16 bits
        send(65025, 65025, 65025, 65025, 0, c1);
        wait_valid("t3_valid", lat);
        check("t3_sum18", a_sum, 260100);
        check("t3_sat18", a_sat, 0);
`ifdef SUM_REDUCE_SAT_EN
        check("t3_sum16", b_sum, 65535);
        check("t3_sat16", b_sat, 1);
`else
        check("t3_sum16", b_sum, 63492);
        check("t3_sat16", b_sat, 0);
`endif
        drain();

        // Reset in the middle of a reduction
        send(2, 8, 18, 32, 0, c1);
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check("t4_valid", a_out_valid, 0);
        check("t4_sum", a_sum, 0);
        check("t4_cnt", a_cnt, 0);
        check("t4_ready", a_in_ready, 1);
        send(1, 1, 1, 1, 0, c1);
        wait_valid("t4b_valid", lat);
        check("t4b_sum", a_sum, 4);
        drain();

        // Back-to-back with in_valid held high
        send(1, 2, 3, 4, 1, c1);
        send(5, 6, 7, 8, 0, c2);
        check("t5_spacing", c2 - c1, 6);
        check("t5_first_sum", a_sum, 10);
        wait_valid("t5_valid", lat);
        check("t5_second_sum", a_sum, 26);
        drain();

        // Inputs changed after acceptance must not leak into the result
        send(1, 2, 3, 4, 0, c1);
        for (int i = 0; i < 4; i++) prod[i] = 16'd100;
        wait_valid("t6_valid", lat);
        check("t6_sum", a_sum, 10);
        drain();

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
